// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared constants for the register file and its scoreboard
package regfile_sb_pkg;
  localparam int XLEN = 64;
  localparam int CNT_W = 2;
  localparam int NUM_REGS = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_A0 = 5'd10;
endpackage

// File: rtl/regfile_sb_counter.sv
// sb_counter: saturating pending-write counter with clear; simultaneous inc and dec cancel
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic up, dn;
  assign up = inc && !(&cnt);
  assign dn = dec && (|cnt);
  // count issued writes up, landed writes down, never past either end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : cnt + W'(up && !dn) - W'(dn && !inc);
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 32 x XLEN register file with write bypass and pending-write issue scoreboard
module regfile_sb import regfile_sb_pkg::*; #(
  parameter int XLEN_P = XLEN,
  parameter int CNT_P = CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen_i,
  input  logic [4:0]        rd_i,
  input  logic [XLEN_P-1:0] rf_wdata_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  output logic [XLEN_P-1:0] rs1_data_o,
  output logic [XLEN_P-1:0] rs2_data_o,
  input  logic              issue_i,
  input  logic              issue_wen_i,
  input  logic [4:0]        issue_rd_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [XLEN_P-1:0] a0_o
);
  logic [XLEN_P-1:0] regs [NUM_REGS];
  logic [CNT_P-1:0] cnt [NUM_REGS];
  logic wb_ok, hit1, hit2, busy1, busy2, full, inc_ok;
  assign wb_ok = wen_i && rd_i != REG_ZERO;
  assign hit1 = wb_ok && rd_i == rs1_i;
  assign hit2 = wb_ok && rd_i == rs2_i;
  assign rs1_data_o = !rst_n ? '0 : hit1 ? rf_wdata_i : regs[rs1_i];
  assign rs2_data_o = !rst_n ? '0 : hit2 ? rf_wdata_i : regs[rs2_i];
  assign a0_o = regs[REG_A0];
  // a write landing this cycle is covered by the bypass, so it no longer counts as outstanding
  assign busy1 = rs1_used_i && rs1_i != REG_ZERO && cnt[rs1_i] > {{(CNT_P-1){1'b0}}, hit1};
  assign busy2 = rs2_used_i && rs2_i != REG_ZERO && cnt[rs2_i] > {{(CNT_P-1){1'b0}}, hit2};
  assign full = issue_wen_i && issue_rd_i != REG_ZERO && (&cnt[issue_rd_i]);
  assign stall_o = rst_n && issue_i && (busy1 || busy2 || full);
  assign inc_ok = issue_i && !stall_o && issue_wen_i;
  assign cnt[0] = '0;
  generate
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
      sb_counter #(.W(CNT_P)) u_cnt (
        .clk(clk),
        .rst_n(rst_n),
        .inc(inc_ok && issue_rd_i == 5'(i)),
        .dec(wen_i && rd_i == 5'(i)),
        .clr(flush_i),
        .cnt(cnt[i])
      );
    end
  endgenerate
  // architectural write; x0 is never written so it always reads zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    else if (wb_ok) regs[rd_i] <= rf_wdata_i;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized and directed scoreboard bench against a register-file reference model
module tb_regfile_sb;
  logic clk = 0;
  logic rst_n = 0;
  logic wen_i, rs1_used_i, rs2_used_i, issue_i, issue_wen_i, flush_i, stall_o;
  logic [4:0] rd_i, rs1_i, rs2_i, issue_rd_i;
  logic [63:0] rf_wdata_i, rs1_data_o, rs2_data_o, a0_o;

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .wen_i(wen_i), .rd_i(rd_i), .rf_wdata_i(rf_wdata_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .issue_i(issue_i),
    .issue_wen_i(issue_wen_i), .issue_rd_i(issue_rd_i), .flush_i(flush_i),
    .stall_o(stall_o), .a0_o(a0_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d1, d2, a0;
    logic st;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  logic [63:0] m_reg [32];
  int m_cnt [32];

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin
      m_reg[k] = 0;
      m_cnt[k] = 0;
    end
  endtask

  // outputs from the pre-edge architectural state, then advance the model to the post-edge state
  task automatic model_step();
    exp_t e;
    bit h1, h2, b1, b2, stl, dec;
    if (!rst_n) begin
      model_reset();
      e.d1 = 0; e.d2 = 0; e.a0 = 0; e.st = 0;
      q.push_back(e);
      return;
    end
    h1 = wen_i && rd_i != 0 && rd_i == rs1_i;
    h2 = wen_i && rd_i != 0 && rd_i == rs2_i;
    e.d1 = rs1_i == 0 ? 64'd0 : h1 ? rf_wdata_i : m_reg[rs1_i];
    e.d2 = rs2_i == 0 ? 64'd0 : h2 ? rf_wdata_i : m_reg[rs2_i];
    e.a0 = m_reg[10];
    b1 = rs1_used_i && rs1_i != 0 && (m_cnt[rs1_i] - int'(h1)) > 0;
    b2 = rs2_used_i && rs2_i != 0 && (m_cnt[rs2_i] - int'(h2)) > 0;
    stl = issue_i && (b1 || b2 || (issue_wen_i && issue_rd_i != 0 && m_cnt[issue_rd_i] == 3));
    e.st = stl;
    q.push_back(e);
    dec = wen_i && rd_i != 0 && m_cnt[rd_i] > 0;
    if (wen_i && rd_i != 0) m_reg[rd_i] = rf_wdata_i;
    if (flush_i) for (int k = 0; k < 32; k++) m_cnt[k] = 0;
    else begin
      if (issue_i && !stl && issue_wen_i && issue_rd_i != 0) m_cnt[issue_rd_i]++;
      if (dec) m_cnt[rd_i]--;
    end
  endtask

  task automatic drv(input logic rst, input logic wen, input logic [4:0] rd, input logic [63:0] wd,
                     input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                     input logic iss, input logic iwen, input logic [4:0] ird, input logic fl);
    @(negedge clk);
    rst_n = rst; wen_i = wen; rd_i = rd; rf_wdata_i = wd;
    rs1_i = r1; rs1_used_i = u1; rs2_i = r2; rs2_used_i = u2;
    issue_i = iss; issue_wen_i = iwen; issue_rd_i = ird; flush_i = fl;
    #1 model_step();
  endtask

  function automatic logic [4:0] rreg();
    return 5'($urandom_range(0, 11));
  endfunction

  task automatic rnd(input logic rst);
    drv(rst, $urandom_range(0, 2) == 0, rreg(), {$urandom, $urandom}, rreg(), 1'($urandom),
        rreg(), 1'($urandom), $urandom_range(0, 2) != 0, 1'($urandom), rreg(),
        $urandom_range(0, 15) == 0);
  endtask

  // monitor: compare whatever the DUT presents against the oldest expectation
  initial forever begin
    @(negedge clk);
    #2;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (rs1_data_o !== e.d1) begin
        miscompares++;
        $display("FAIL rs1_data t=%0t got %h want %h", $time, rs1_data_o, e.d1);
      end
      if (rs2_data_o !== e.d2) begin
        miscompares++;
        $display("FAIL rs2_data t=%0t got %h want %h", $time, rs2_data_o, e.d2);
      end
      if (a0_o !== e.a0) begin
        miscompares++;
        $display("FAIL a0 t=%0t got %h want %h", $time, a0_o, e.a0);
      end
      if (stall_o !== e.st) begin
        miscompares++;
        $display("FAIL stall t=%0t got %b want %b", $time, stall_o, e.st);
      end
    end
  end

  initial begin
    model_reset();
    drv(0, 1, 5'd3, 64'h99, 5'd3, 1, 5'd3, 1, 1, 1, 5'd3, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // basic write, x0 write ignored, a0 path
    drv(1, 1, 5'd5, 64'hDEAD_BEEF, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    drv(1, 1, 5'd0, 64'd7, 5'd5, 1, 5'd0, 1, 0, 0, 0, 0);
    drv(1, 1, 5'd10, 64'hA0A0, 5'd0, 1, 5'd5, 1, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 5'd10, 1, 5'd0, 0, 0, 0, 0, 0);
    // same-cycle bypass
    drv(1, 1, 5'd6, 64'h1234, 5'd5, 0, 5'd6, 1, 0, 0, 0, 0);
    // dependency stall released by the landing write
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'd7, 0);
    drv(1, 0, 0, 0, 5'd7, 1, 0, 0, 1, 0, 0, 0);
    drv(1, 1, 5'd7, 64'h55, 5'd7, 1, 0, 0, 1, 0, 0, 0);
    // counter saturation stalls a fourth issue; unused source does not stall
    for (int k = 0; k < 4; k++) drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'd8, 0);
    drv(1, 0, 0, 0, 5'd8, 0, 5'd8, 0, 1, 0, 0, 0);
    drv(1, 0, 0, 0, 5'd8, 1, 0, 0, 1, 0, 0, 0);
    // flush clears tracking; a late writeback leaves the counter at zero
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'd9, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drv(1, 0, 0, 0, 5'd9, 1, 5'd8, 1, 1, 0, 0, 0);
    drv(1, 1, 5'd9, 64'h77, 5'd9, 1, 0, 0, 1, 0, 0, 0);
    drv(1, 0, 0, 0, 5'd9, 1, 0, 0, 1, 0, 0, 0);
    // random traffic with an asynchronous reset in the middle
    for (int k = 0; k < 300; k++) rnd(1);
    rnd(0);
    rnd(0);
    for (int k = 0; k < 300; k++) rnd(1);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #3;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
